// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // alu_op from the FSM to the ALU decoder
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the FSM's alu_op and the instruction funct field to alu_ctrl.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [SEL_W-1:0] alu_op,
  input  logic [OP_W-1:0]  funct,
  output logic [ALU_W-1:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: steps each instruction through fetch, decode,
// execute/memory and writeback, driving datapath enables and mux selects.
module mc_control
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic [SEL_W-1:0]   pc_src,
  output logic               pc_en,
  output logic [STATE_W-1:0] state
);

  state_t             state_q;
  state_t             state_d;
  logic               mem_ok;
  logic               pc_write;
  logic               branch;
  logic [SEL_W-1:0]   alu_op;
  logic [ALU_W-1:0]   alu_ctrl_dec;

  // Without wait support every memory access completes in its first cycle
  assign mem_ok = !MEM_WAIT_EN || mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    branch     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ok) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ok ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ok ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (branch & zero);

    // Reset kills every strobe at once, including a write still in flight
    if (rst) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      pc_src     = PCSRC_ALU;
      pc_en      = 1'b0;
    end
  end

  mc_alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl_dec)
  );

  assign alu_ctrl = rst ? ALU_W'(0) : alu_ctrl_dec;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle vector table through a scoreboard queue, plus
// hand sequences for async reset during a write and the no-wait memory variant.
module tb_mc_control;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, mem_write, iord, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_en;
  } out_t;

  typedef struct { out_t v; out_t m; } exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    exp_t       e;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic n_mem_req, n_mem_write, n_iord, n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write;
  logic n_alu_src_a, n_pc_en;
  logic [1:0] n_alu_src_b, n_pc_src;
  logic [2:0] n_alu_ctrl;
  logic [3:0] n_state;
  out_t act1, act2;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  exp_t sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mc_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en), .state(state)
  );

  mc_control #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .rst(rst2), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_write(n_mem_write), .iord(n_iord), .ir_write(n_ir_write),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_ctrl(n_alu_ctrl),
    .pc_src(n_pc_src), .pc_en(n_pc_en), .state(n_state)
  );

  assign act1 = {state, mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en};
  assign act2 = {n_state, n_mem_req, n_mem_write, n_iord, n_ir_write, n_reg_dst, n_mem_to_reg,
                 n_reg_write, n_alu_src_a, n_alu_src_b, n_alu_ctrl, n_pc_src, n_pc_en};

  // Expected-value builders: state plus all strobes always checked, selects only where defined
  function automatic exp_t ex(input logic [3:0] st);
    exp_t e;
    e.v = '0;
    e.m = '0;
    e.v.state = st;
    e.m.state = 4'hF;
    e.m.mem_req = 1'b1; e.m.mem_write = 1'b1; e.m.ir_write = 1'b1;
    e.m.reg_write = 1'b1; e.m.pc_en = 1'b1;
    return e;
  endfunction

  function automatic exp_t alu(input exp_t ei, input logic a, input logic [1:0] b,
                               input logic [2:0] c);
    exp_t e = ei;
    e.v.alu_src_a = a; e.m.alu_src_a = 1'b1;
    e.v.alu_src_b = b; e.m.alu_src_b = 2'b11;
    e.v.alu_ctrl = c;  e.m.alu_ctrl = 3'b111;
    return e;
  endfunction

  function automatic exp_t e_reset();
    exp_t e;
    e.v = '0;
    e.m = '1;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic r);
    exp_t e = alu(ex(4'd0), 1'b0, 2'b01, 3'b010);
    e.v.mem_req = 1'b1;
    e.v.ir_write = r;
    e.v.pc_en = r;
    e.m.iord = 1'b1;
    e.m.pc_src = 2'b11;
    return e;
  endfunction

  function automatic exp_t e_decode();
    return alu(ex(4'd1), 1'b0, 2'b11, 3'b010);
  endfunction

  function automatic exp_t e_memadr();
    return alu(ex(4'd2), 1'b1, 2'b10, 3'b010);
  endfunction

  function automatic exp_t e_memrd();
    exp_t e = ex(4'd3);
    e.v.mem_req = 1'b1;
    e.v.iord = 1'b1; e.m.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [3:0] st, input logic rd, input logic m2r);
    exp_t e = ex(st);
    e.v.reg_write = 1'b1;
    e.v.reg_dst = rd;     e.m.reg_dst = 1'b1;
    e.v.mem_to_reg = m2r; e.m.mem_to_reg = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_memwr();
    exp_t e = ex(4'd5);
    e.v.mem_req = 1'b1;
    e.v.mem_write = 1'b1;
    e.v.iord = 1'b1; e.m.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [2:0] c);
    return alu(ex(4'd6), 1'b1, 2'b00, c);
  endfunction

  function automatic exp_t e_branch(input logic z);
    exp_t e = alu(ex(4'd8), 1'b1, 2'b00, 3'b110);
    e.v.pc_src = 2'b01; e.m.pc_src = 2'b11;
    e.v.pc_en = z;
    return e;
  endfunction

  function automatic exp_t e_addiex();
    return alu(ex(4'd9), 1'b1, 2'b10, 3'b010);
  endfunction

  function automatic exp_t e_jump();
    exp_t e = ex(4'd11);
    e.v.pc_src = 2'b10; e.m.pc_src = 2'b11;
    e.v.pc_en = 1'b1;
    return e;
  endfunction

  task automatic add_vec(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic rd, input exp_t e, input string t);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rd; v.e = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [2:0] c, input string t);
    add_vec(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_fetch(1'b1), {t, "_fetch"});
    add_vec(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_decode(), {t, "_dec"});
    add_vec(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_exec(c), {t, "_exec"});
    add_vec(1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_wb(4'd7, 1'b1, 1'b0), {t, "_wb"});
  endtask

  task automatic check(input out_t act, input exp_t e, input string t);
    logic [19:0] d;
    d = (act ^ e.v) & e.m;
    checks++;
    if (d !== 20'h0) begin
      failures++;
      $display("FAIL %s: got=%05h expected=%05h care=%05h", t, act, e.v, e.m);
    end
  endtask

  // One clock: drive after the edge, queue the expectation, compare mid-cycle
  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic rd, input exp_t e, input string t,
                      input bit use2);
    @(posedge clk);
    #1;
    rst = r; op = o; funct = f; zero = z; mem_ready = rd;
    sb_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    if (use2) check(act2, sb_q.pop_front(), tag_q.pop_front());
    else      check(act1, sb_q.pop_front(), tag_q.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add_vec(1'b1, 6'h0, 6'h0, 1'b0, 1'b1, e_reset(), "reset0");
    add_vec(1'b1, 6'h0, 6'h0, 1'b0, 1'b1, e_reset(), "reset1");
    add_rtype(FN_ADD, ALU_ADD, "add");
    add_rtype(FN_SUB, ALU_SUB, "sub");
    add_rtype(FN_AND, ALU_AND, "and");
    add_rtype(FN_OR,  ALU_OR,  "or");
    add_rtype(FN_SLT, ALU_SLT, "slt");
    add_rtype(6'b000111, ALU_ADD, "fnother");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b1, e_decode(), "lw_dec");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b0, e_memadr(), "lw_adr");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b0, e_memrd(), "lw_rd_wait0");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b0, e_memrd(), "lw_rd_wait1");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b1, e_memrd(), "lw_rd_ready");
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, 1'b1, e_wb(4'd4, 1'b0, 1'b1), "lw_wb");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "beqt_fetch");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b0, 1'b1, e_decode(), "beqt_dec");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b1, 1'b1, e_branch(1'b1), "beqt_branch");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "beqn_fetch");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b0, 1'b1, e_decode(), "beqn_dec");
    add_vec(1'b0, OP_BEQ, 6'h0, 1'b0, 1'b1, e_branch(1'b0), "beqn_branch");
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, 1'b1, e_decode(), "sw_dec");
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, 1'b0, e_memadr(), "sw_adr");
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, 1'b0, e_memwr(), "sw_wr_wait");
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, 1'b1, e_memwr(), "sw_wr_ready");
    add_vec(1'b0, 6'h3F, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "ill_fetch");
    add_vec(1'b0, 6'h3F, 6'h0, 1'b0, 1'b1, e_decode(), "ill_dec");
    add_vec(1'b0, OP_J, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "j_fetch");
    add_vec(1'b0, OP_J, 6'h0, 1'b0, 1'b1, e_decode(), "j_dec");
    add_vec(1'b0, OP_J, 6'h0, 1'b0, 1'b1, e_jump(), "j_jump");
    add_vec(1'b0, OP_ADDI, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "addi_fetch");
    add_vec(1'b0, OP_ADDI, 6'h0, 1'b0, 1'b1, e_decode(), "addi_dec");
    add_vec(1'b0, OP_ADDI, 6'h0, 1'b0, 1'b1, e_addiex(), "addi_ex");
    add_vec(1'b0, OP_ADDI, 6'h0, 1'b0, 1'b1, e_wb(4'd10, 1'b0, 1'b0), "addi_wb");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].rdy,
           vecs[i].e, vecs[i].tag, 1'b0);

    // Asynchronous reset while a store is waiting for acceptance
    step(1'b0, OP_SW, 6'h0, 1'b0, 1'b1, e_fetch(1'b1), "ar_fetch", 1'b0);
    step(1'b0, OP_SW, 6'h0, 1'b0, 1'b1, e_decode(), "ar_dec", 1'b0);
    step(1'b0, OP_SW, 6'h0, 1'b0, 1'b0, e_memadr(), "ar_adr", 1'b0);
    step(1'b0, OP_SW, 6'h0, 1'b0, 1'b0, e_memwr(), "ar_wr", 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check(act1, e_reset(), "ar_async_drop");
    step(1'b1, OP_SW, 6'h0, 1'b0, 1'b0, e_reset(), "ar_hold", 1'b0);
    step(1'b0, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_fetch(1'b1), "ar_resume_fetch", 1'b0);
    step(1'b0, OP_RTYPE, FN_ADD, 1'b0, 1'b1, e_decode(), "ar_resume_dec", 1'b0);

    // No-wait variant: mem_ready held low must not stall a load
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst = 1'b1;
    op = OP_LW;
    mem_ready = 1'b0;
    @(negedge clk);
    check(act2, e_fetch(1'b1), "nw_fetch");
    step(1'b1, OP_LW, 6'h0, 1'b0, 1'b0, e_decode(), "nw_dec", 1'b1);
    step(1'b1, OP_LW, 6'h0, 1'b0, 1'b0, e_memadr(), "nw_adr", 1'b1);
    step(1'b1, OP_LW, 6'h0, 1'b0, 1'b0, e_memrd(), "nw_rd", 1'b1);
    step(1'b1, OP_LW, 6'h0, 1'b0, 1'b0, e_wb(4'd4, 1'b0, 1'b1), "nw_wb", 1'b1);
    step(1'b1, OP_LW, 6'h0, 1'b0, 1'b0, e_fetch(1'b1), "nw_next_fetch", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
